// File: rtl/storage_spi_responder_pkg.sv
// Shared types and constants for the storage SPI responder.
package storage_spi_responder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddrHi,
    StAddrLo,
    StRead,
    StWrite,
    StIgnore
  } state_e;

  localparam logic [7:0]  CMD_READ_DEF  = 8'h03;
  localparam logic [7:0]  CMD_WRITE_DEF = 8'h02;
  localparam int unsigned SYNC_STAGES   = 2;

endpackage

// File: rtl/storage_spi_sync.sv
// Two-flop synchroniser for one SPI line plus a history flop producing one-cycle edge pulses.
module storage_spi_sync
  import storage_spi_responder_pkg::*;
#(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{ResetVal}};
      hist_q <= ResetVal;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/storage_spi_responder.sv
// SPI mode-0 storage responder: decodes READ/WRITE frames from an oversampled bus and
// serves or stores bytes in an internal RAM.
module storage_spi_responder
  import storage_spi_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0]  CMD_WRITE = CMD_WRITE_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_storeSCS,
  input  logic i_storeSCK,
  input  logic i_storeSDI,
  output logic o_storeSDO,
  output logic o_sdoEn,
  output logic o_busy,
  output logic o_cmdErr
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic scs_lvl, scs_rise, scs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  storage_spi_sync #(.ResetVal(1'b1)) u_sync_scs (
    .clk_i(i_clk), .rst_i(i_rst), .pin_i(i_storeSCS),
    .level_o(scs_lvl), .rise_o(scs_rise), .fall_o(scs_fall)
  );
  storage_spi_sync #(.ResetVal(1'b0)) u_sync_sck (
    .clk_i(i_clk), .rst_i(i_rst), .pin_i(i_storeSCK),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  storage_spi_sync #(.ResetVal(1'b0)) u_sync_sdi (
    .clk_i(i_clk), .rst_i(i_rst), .pin_i(i_storeSDI),
    .level_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_in_q, shift_in_d, shift_out_q, shift_out_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_read_q, is_read_d, rd_valid_q, rd_valid_d;
  logic              sdo_q, sdo_d, sdo_en_q, sdo_en_d, busy_q, busy_d, cmd_err_q, cmd_err_d;
  logic              armed_q, armed_d;
  logic [1:0]        warm_q, warm_d;

  logic [7:0]        byte_val, ram_rdata_q;
  logic [15:0]       bus_addr;
  logic              byte_done, ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        mem [Depth];

  logic unused_bits;
  assign unused_bits = ^{sck_lvl, sdi_rise, sdi_fall, bus_addr[15:ADDR_W]};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    cmd_err_d   = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    byte_done   = 1'b0;
    byte_val    = {shift_in_q[6:0], sdi_lvl};
    bus_addr    = {addr_hi_q, byte_val};
    // A frame may only open once SCS has been seen high after reset, so a reset in the
    // middle of a frame skips the rest of that frame.
    warm_d      = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    armed_d     = armed_q | ((warm_q == 2'd2) & scs_lvl);

    if (state_q != StIdle && sck_rise) begin
      shift_in_d = byte_val;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      byte_done  = (bit_cnt_q == 3'd7);
    end

    if (state_q == StRead && rd_valid_q) begin
      shift_out_d = ram_rdata_q;
    end else if (state_q == StRead && sck_fall) begin
      shift_out_d = {shift_out_q[6:0], 1'b0};
    end

    unique case (state_q)
      StIdle: begin
        if (scs_fall && armed_q) begin
          state_d    = StCmd;
          bit_cnt_d  = 3'd0;
          shift_in_d = 8'd0;
        end
      end
      StCmd: begin
        if (byte_done) begin
          if (byte_val == CMD_READ || byte_val == CMD_WRITE) begin
            state_d   = StAddrHi;
            is_read_d = (byte_val == CMD_READ);
          end else begin
            state_d   = StIgnore;
            cmd_err_d = 1'b1;
          end
        end
      end
      StAddrHi: begin
        if (byte_done) begin
          addr_hi_d = byte_val;
          state_d   = StAddrLo;
        end
      end
      StAddrLo: begin
        if (byte_done) begin
          addr_d  = bus_addr[ADDR_W-1:0];
          state_d = is_read_q ? StRead : StWrite;
          ram_re  = is_read_q;
        end
      end
      StRead: begin
        if (byte_done) begin
          addr_d = addr_q + ADDR_W'(1);
          ram_re = 1'b1;
        end
      end
      StWrite: begin
        if (byte_done) begin
          addr_d = addr_q + ADDR_W'(1);
          ram_we = 1'b1;
        end
      end
      StIgnore: ;
      default: state_d = StIdle;
    endcase

    // Deselect wins over any same-cycle SCK edge; a partial byte is dropped.
    if (scs_rise) begin
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      cmd_err_d = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
    end

    ram_addr   = (state_q == StWrite) ? addr_q : addr_d;
    rd_valid_d = ram_re;
    sdo_d      = 1'b0;
    if (state_d == StRead) begin
      sdo_d = (state_q == StRead && sck_fall) ? shift_out_q[7] : sdo_q;
    end
    sdo_en_d = (state_d == StRead);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'd0;
      shift_out_q <= 8'd0;
      addr_hi_q   <= 8'd0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      sdo_q       <= 1'b0;
      sdo_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      armed_q     <= 1'b0;
      warm_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      rd_valid_q  <= rd_valid_d;
      sdo_q       <= sdo_d;
      sdo_en_q    <= sdo_en_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
      armed_q     <= armed_d;
      warm_q      <= warm_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      mem[ram_addr] <= byte_val;
    end
    if (ram_re) begin
      ram_rdata_q <= mem[ram_addr];
    end
  end

  assign o_storeSDO = sdo_q;
  assign o_sdoEn    = sdo_en_q;
  assign o_busy     = busy_q;
  assign o_cmdErr   = cmd_err_q;

endmodule
